dimmer_button_frontend: RTL and testbench

Input-side front end for the LED dimmer state machine. It turns two raw, bouncing, asynchronous push-buttons into the single-cycle `up`/`down` command pulses that the dimmer consumes. A near-simultaneous press of both buttons is merged into one cycle with both pulses high, which is the dimmer's "off" command. The block sits between the board button pins and the dimmer's `i_up`/`i_down` inputs, in the same clock domain.

---
 rtl/dimmer_button_frontend.sv | 162 ++++++++++++++++
 tb/tb_dimmer_button_frontend.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dimmer_button_frontend.sv
// ============================================================================
// Module   : dimmer_button_frontend
// Brief    : Synchronizes and debounces two raw push-buttons and turns them
//            into single-cycle up/down command pulses; a near-simultaneous
//            press of both buttons becomes one cycle with both pulses high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dimmer_button_frontend #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PAIR_WINDOW     = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_up,
    input  logic i_btn_down,
    output logic o_up,
    output logic o_down
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WIN_W = $clog2(PAIR_WINDOW + 1);

    localparam logic [DB_W-1:0]  DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
    // The window counter clears on the cycle after the press event, so the
    // last in-window count is two short of the window length; the resulting
    // pulse then lands exactly PAIR_WINDOW cycles after the press event.
    localparam logic [WIN_W-1:0] WIN_EXPIRE = WIN_W'(PAIR_WINDOW - 2);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DOWN = 2'd1,
        S_WAIT_UP   = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    // Index 0 is the up button, index 1 is the down button.
    logic [1:0] raw_w;
    logic [1:0] level_w;
    logic [1:0] press_w;
    logic [1:0] release_w;

    assign raw_w = {i_btn_down, i_btn_up};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            level_q;
        logic            prev_q;
        logic [DB_W-1:0] cnt_q;

        // Two-flop synchronizer, saturating mismatch counter and edge register.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                prev_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_w[b];
                sync2_q <= sync1_q;
                prev_q  <= level_q;
                if (sync2_q != level_q) begin
                    // The count never exceeds the limit: reaching it commits
                    // the new level and clears the counter in one step.
                    if (cnt_q == DB_LIMIT) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign level_w[b]   = level_q;
        assign press_w[b]   = level_q & ~prev_q;
        assign release_w[b] = ~level_q & prev_q;
    end

    state_t           state_q;
    logic [WIN_W-1:0] win_q;
    logic             up_q;
    logic             down_q;
    logic             win_expired_w;

    assign win_expired_w = (win_q == WIN_EXPIRE);

    // Pairing state machine with registered command pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (press_w[0] && press_w[1]) begin
                        up_q    <= 1'b1;
                        down_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end else if (press_w[0]) begin
                        win_q   <= '0;
                        state_q <= S_WAIT_DOWN;
                    end else if (press_w[1]) begin
                        win_q   <= '0;
                        state_q <= S_WAIT_UP;
                    end
                end
                S_WAIT_DOWN: begin
                    if (!win_expired_w) begin
                        win_q <= win_q + 1'b1;
                    end
                    // A partner press wins even on the expiry cycle.
                    if (press_w[1]) begin
                        up_q    <= 1'b1;
                        down_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end else if (release_w[0] || win_expired_w) begin
                        up_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_UP: begin
                    if (!win_expired_w) begin
                        win_q <= win_q + 1'b1;
                    end
                    if (press_w[0]) begin
                        up_q    <= 1'b1;
                        down_q  <= 1'b1;
                        state_q <= S_HOLD;
                    end else if (release_w[1] || win_expired_w) begin
                        down_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Stay quiet until both buttons are fully released.
                    if (level_w == 2'b00) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_up   = up_q;
    assign o_down = down_q;

endmodule

`default_nettype wire

// File: tb/tb_dimmer_button_frontend.sv
// ============================================================================
// Module   : tb_dimmer_button_frontend
// Brief    : Directed self-checking bench for dimmer_button_frontend with
//            DEBOUNCE_CYCLES=4 and PAIR_WINDOW=8. Cycle c is the c-th rising
//            edge after reset release; outputs are sampled #1 after it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dimmer_button_frontend;

    logic clk;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic o_up;
    logic o_down;

    int total;
    int bad;

    dimmer_button_frontend #(
        .DEBOUNCE_CYCLES(4),
        .PAIR_WINDOW    (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn_up  (btn_up),
        .i_btn_down(btn_down),
        .o_up      (o_up),
        .o_down    (o_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs mid-cycle, then advance to just after the next rising edge.
    task automatic step(input logic up, input logic dn, input logic r);
        @(negedge clk);
        btn_up   = up;
        btn_down = dn;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for a few cycles with buttons low; next step is cycle 0.
    task automatic apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            total++;
            if (o_up !== 1'b0 || o_down !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold i=%0d got up=%b down=%b want 0 0", i, o_up, o_down);
            end
        end
        for (int c = 0; c < 50; c++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (o_up !== 1'b0 || o_down !== 1'b0) begin
                bad++;
                $display("FAIL idle_low c=%0d got up=%b down=%b want 0 0", c, o_up, o_down);
            end
        end
    endtask

    // Up held 10..49: debounced at 16, single pulse by window expiry at 24.
    task automatic test_single_window();
        logic u;
        logic exp_u;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u     = (c >= 10 && c < 50);
            exp_u = (c == 24);
            step(u, 1'b0, 1'b0);
            total++;
            if (o_up !== exp_u || o_down !== 1'b0) begin
                bad++;
                $display("FAIL single_window c=%0d got up=%b down=%b want %b 0", c, o_up, o_down, exp_u);
            end
        end
    endtask

    // Up toggling every 2 cycles never survives the 4-count filter.
    task automatic test_bounce();
        logic u;
        apply_reset();
        for (int c = 0; c < 60; c++) begin
            u = (c >= 10 && c < 30) ? (((c - 10) % 4) < 2) : 1'b0;
            step(u, 1'b0, 1'b0);
            total++;
            if (o_up !== 1'b0 || o_down !== 1'b0) begin
                bad++;
                $display("FAIL bounce c=%0d got up=%b down=%b want 0 0", c, o_up, o_down);
            end
        end
    endtask

    // Up at 10, down at 13 -> pair at 20; both at 10 -> pair at 17.
    task automatic test_pair();
        logic u;
        logic d;
        logic e;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u = (c >= 10 && c < 50);
            d = (c >= 13 && c < 53);
            e = (c == 20);
            step(u, d, 1'b0);
            total++;
            if (o_up !== e || o_down !== e) begin
                bad++;
                $display("FAIL pair_staggered c=%0d got up=%b down=%b want %b %b", c, o_up, o_down, e, e);
            end
        end
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u = (c >= 10 && c < 50);
            e = (c == 17);
            step(u, u, 1'b0);
            total++;
            if (o_up !== e || o_down !== e) begin
                bad++;
                $display("FAIL pair_same c=%0d got up=%b down=%b want %b %b", c, o_up, o_down, e, e);
            end
        end
    endtask

    // Down held for five samples (10..14): debounced rise at 16, fall at 21,
    // early-release pulse at 22, ahead of the window expiry at 24.
    task automatic test_early_release();
        logic d;
        logic exp_d;
        apply_reset();
        for (int c = 0; c < 50; c++) begin
            d     = (c >= 10 && c < 15);
            exp_d = (c == 22);
            step(1'b0, d, 1'b0);
            total++;
            if (o_up !== 1'b0 || o_down !== exp_d) begin
                bad++;
                $display("FAIL early_release c=%0d got up=%b down=%b want 0 %b", c, o_up, o_down, exp_d);
            end
        end
    endtask

    // Reset at 18..19 drops the pending press; held button re-debounces
    // to rise at 26 and pulses at 34.
    task automatic test_reset_pending();
        logic u;
        logic r;
        logic exp_u;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u     = (c >= 10 && c < 60);
            r     = (c == 18 || c == 19);
            exp_u = (c == 34);
            step(u, 1'b0, r);
            total++;
            if (o_up !== exp_u || o_down !== 1'b0) begin
                bad++;
                $display("FAIL reset_pending c=%0d got up=%b down=%b want %b 0", c, o_up, o_down, exp_u);
            end
        end
    endtask

    // Up held long (pulse at 24, no repeat); down pressed while up still
    // held rises at 46 and yields a lone down pulse at 54.
    task automatic test_held_then_other();
        logic u;
        logic d;
        logic exp_u;
        logic exp_d;
        apply_reset();
        for (int c = 0; c < 110; c++) begin
            u     = (c >= 10 && c < 70);
            d     = (c >= 40 && c < 80);
            exp_u = (c == 24);
            exp_d = (c == 54);
            step(u, d, 1'b0);
            total++;
            if (o_up !== exp_u || o_down !== exp_d) begin
                bad++;
                $display("FAIL held_then_other c=%0d got up=%b down=%b want %b %b", c, o_up, o_down, exp_u, exp_d);
            end
        end
    endtask

    // Window boundary: down press event at 23 still pairs (pulse 24);
    // press event at 24 misses, giving up at 24 and a lone down at 32.
    task automatic test_window_edge();
        logic u;
        logic d;
        logic e;
        logic exp_u;
        logic exp_d;
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u = (c >= 10 && c < 50);
            d = (c >= 17 && c < 50);
            e = (c == 24);
            step(u, d, 1'b0);
            total++;
            if (o_up !== e || o_down !== e) begin
                bad++;
                $display("FAIL window_last c=%0d got up=%b down=%b want %b %b", c, o_up, o_down, e, e);
            end
        end
        apply_reset();
        for (int c = 0; c < 80; c++) begin
            u     = (c >= 10 && c < 50);
            d     = (c >= 18 && c < 50);
            exp_u = (c == 24);
            exp_d = (c == 32);
            step(u, d, 1'b0);
            total++;
            if (o_up !== exp_u || o_down !== exp_d) begin
                bad++;
                $display("FAIL window_missed c=%0d got up=%b down=%b want %b %b", c, o_up, o_down, exp_u, exp_d);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        test_reset();
        test_single_window();
        test_bounce();
        test_pair();
        test_early_release();
        test_reset_pending();
        test_held_then_other();
        test_window_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
